collision_detector: RTL and testbench
=====================================

Name: collision_detector

Overview:
- Downstream stage of the SHA1 hasher lanes; replaces ad-hoc hash compare and golden-nonce capture in the collision top level.
- Carries each issued base nonce through a delay line matched to the expand+hash latency, so a target-hash match reports the exact nonce that produced it.
- Holds the result for the JTAG comm block and halts the BCD nonce counter until the host acknowledges.

Parameters:
- NUM_LANES, 2, number of parallel hasher lanes; lane i hashes base_nonce + i (BCD).
- HASH_LATENCY, 82, cycles from rx_nonce_valid/rx_nonce_base sample to the corresponding rx_hash word at this block's input (expand 1 + sha1 80 + add 1).
- NONCE_W, 60, nonce width (15 BCD digits).

Ports:
- clk  in  1  hash clock
- rst_n  in  1  asynchronous active-low reset
- rx_nonce_valid  in  1  base nonce issued this cycle
- rx_nonce_base  in  NONCE_W  base nonce issued this cycle
- rx_hash  in  NUM_LANES*160  lane i hash at bits [i*160+159 : i*160]
- rx_target_hash  in  160  hash being searched for; quasi-static
- rx_flush  in  1  sync clear of in-flight valids (target changed)
- rx_ack  in  1  host has read result; 1-cycle pulse
- tx_found  out  1  golden nonce valid and held
- tx_golden_nonce  out  NONCE_W  base nonce of matching lane, or latest checked nonce while searching
- tx_golden_lane  out  clog2(NUM_LANES) (min 1)  matching lane index
- tx_halt  out  1  stop/reset request to nonce counter

Behaviour:
- Reset (async, rst_n=0): delay-line valid bits 0, compare pipeline 0, state SEARCH, tx_found=0, tx_golden_nonce=0, tx_golden_lane=0, tx_halt=0. Nonce payload registers need no reset.
- Delay line: depth HASH_LATENCY+2 of {valid, nonce}. The +2 covers the compare pipeline. Shifts every cycle regardless of state.
- Compare pipeline, per lane:
  - C1: register 5 per-word equalities (32b each) of rx_hash lane vs rx_target_hash.
  - C2: register the AND of the 5 equalities, qualified by the tap valid bit at the matching depth.
  - Total: match for nonce sampled at cycle t appears at cycle t+HASH_LATENCY+2.
- rx_flush: clears all delay-line and C1/C2 valid bits on the next edge. Nonce payloads are untouched. State is unchanged.
- FSM SEARCH:
  - Each cycle with a valid output tap, tx_golden_nonce <= tap nonce (progress monitor).
  - If any lane matches: state <= FOUND, tx_found <= 1, tx_halt <= 1, tx_golden_nonce <= tap nonce, tx_golden_lane <= lowest matching lane index.
  - rx_ack in SEARCH: ignored.
- FSM FOUND:
  - All outputs frozen.
  - Further matches, including in-flight ones, are ignored; the first winner is held.
  - On rx_ack: state <= SEARCH, tx_found <= 0, tx_halt <= 0, and all valid bits are cleared, the same as a flush. This stops stale post-halt nonces from matching.
- Simultaneous rx_ack and a new match in SEARCH: match taken.
- Simultaneous rx_flush and a match at C2 in SEARCH: match taken; flush applies to the line.
- The nonce is reported as base only; the host adds tx_golden_lane in BCD. No arithmetic is done here.
- Reset mid-FOUND: result lost, back to SEARCH with all outputs 0.

Decomposition:
- Shared package/header: SHA1 hash width 160, NONCE_W default, nonce BCD digit count 15, default HASH_LATENCY constant. The top level and this block must agree on these.
- One natural sub-module: nonce_delay_line (parameterised depth/width shift register with valid bit and sync clear).
- Compare and FSM stay in collision_detector.

Test Plan:
- Post-reset garbage: hold rx_nonce_valid=0 for 100 cycles while rx_hash lane0 equals the target -> tx_found stays 0.
- Latency alignment: issue base 000000509803064 at cycle t, rx_nonce_valid=1 throughout; drive lane1 hash = 754d1309a35eb188292dc628947a0e70ab7ccd2a at cycle t+82 -> at t+84 tx_found=1, tx_golden_nonce=000000509803064, tx_golden_lane=1, tx_halt=1.
- Lane priority: both lanes match in the same cycle for base 000000000000010 -> tx_golden_lane=0, nonce 000000000000010.
- Hold after find: second match 5 cycles after the first -> outputs unchanged. rx_ack pulse -> tx_found=0 and tx_halt=0 next cycle. A match already in flight from before the ack is not reported.
- Flush: drive a matching hash 1 cycle after rx_flush for a nonce issued before the flush -> no tx_found. The same stimulus without flush -> tx_found=1.
- Async reset while FOUND: rst_n low mid-cycle -> tx_found, tx_halt and tx_golden_nonce go 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/collision_detector_pkg.sv
// Shared constants and types for the collision search datapath.
// The hasher top level and the collision detector must agree on these values.
package collision_detector_pkg;

    localparam int unsigned HashW              = 160;
    localparam int unsigned WordW              = 32;
    localparam int unsigned HashWords          = HashW / WordW;
    localparam int unsigned NonceDigits        = 15;
    localparam int unsigned NonceWDefault      = NonceDigits * 4;
    localparam int unsigned HashLatencyDefault = 82;

    typedef enum logic [0:0] {
        StSearch = 1'b0,
        StFound  = 1'b1
    } state_e;

endpackage

// File: rtl/nonce_delay_line.sv
// Fixed-depth shift register of {valid, data}; valid bits reset and clear, payload does not.
// Exposes one intermediate valid tap plus the final stage.
module nonce_delay_line #(
    parameter int unsigned Depth = 84,
    parameter int unsigned Width = 60,
    parameter int unsigned Tap   = 82
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             tap_valid_o,
    output logic             out_valid_o,
    output logic [Width-1:0] out_data_o
);

    logic [Depth-1:0] valid_q, valid_d;
    logic [Width-1:0] data_q [Depth];

    always_comb begin
        valid_d = clr_i ? '0 : {valid_q[Depth-2:0], valid_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload is only meaningful alongside its valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        data_q[0] <= data_i;
        for (int i = 1; i < Depth; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign tap_valid_o = valid_q[Tap];
    assign out_valid_o = valid_q[Depth-1];
    assign out_data_o  = data_q[Depth-1];

endmodule

// File: rtl/collision_detector.sv
// Compares lane hashes against the target and captures the exact base nonce that matched.
// Holds the first winner and halts the nonce counter until the host acknowledges.
module collision_detector
    import collision_detector_pkg::*;
#(
    parameter int unsigned NUM_LANES    = 2,
    parameter int unsigned HASH_LATENCY = HashLatencyDefault,
    parameter int unsigned NONCE_W      = NonceWDefault
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                rx_nonce_valid,
    input  logic [NONCE_W-1:0]                                  rx_nonce_base,
    input  logic [NUM_LANES*HashW-1:0]                          rx_hash,
    input  logic [HashW-1:0]                                    rx_target_hash,
    input  logic                                                rx_flush,
    input  logic                                                rx_ack,
    output logic                                                tx_found,
    output logic [NONCE_W-1:0]                                  tx_golden_nonce,
    output logic [((NUM_LANES > 1) ? $clog2(NUM_LANES) : 1)-1:0] tx_golden_lane,
    output logic                                                tx_halt
);

    localparam int unsigned LaneW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned Depth = HASH_LATENCY + 2;

    state_e               state_q;
    logic                 found_q, halt_q;
    logic [NONCE_W-1:0]   nonce_q;
    logic [LaneW-1:0]     lane_q;

    logic                 clr;
    logic                 tap_valid;
    logic                 out_valid;
    logic [NONCE_W-1:0]   out_nonce;

    logic [NUM_LANES-1:0][HashWords-1:0] eq_q, eq_d;
    logic [NUM_LANES-1:0]                match_q, match_d;
    logic [LaneW-1:0]                    win_lane;

    // An ack leaves FOUND and discards everything issued while halted.
    assign clr = rx_flush | ((state_q == StFound) & rx_ack);

    nonce_delay_line #(
        .Depth (Depth),
        .Width (NONCE_W),
        .Tap   (HASH_LATENCY)
    ) u_delay (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr),
        .valid_i     (rx_nonce_valid),
        .data_i      (rx_nonce_base),
        .tap_valid_o (tap_valid),
        .out_valid_o (out_valid),
        .out_data_o  (out_nonce)
    );

    always_comb begin
        eq_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int w = 0; w < HashWords; w++) begin
                eq_d[i][w] = rx_hash[i*HashW + w*WordW +: WordW] ==
                             rx_target_hash[w*WordW +: WordW];
            end
        end
    end

    always_comb begin
        match_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            match_d[i] = (&eq_q[i]) & tap_valid & ~clr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_q    <= '0;
            match_q <= '0;
        end else begin
            eq_q    <= eq_d;
            match_q <= match_d;
        end
    end

    // Lowest index wins when several lanes match together.
    always_comb begin
        win_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (match_q[i]) begin
                win_lane = LaneW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StSearch;
            found_q <= 1'b0;
            halt_q  <= 1'b0;
            nonce_q <= '0;
            lane_q  <= '0;
        end else begin
            unique case (state_q)
                StSearch: begin
                    if (|match_q) begin
                        state_q <= StFound;
                        found_q <= 1'b1;
                        halt_q  <= 1'b1;
                        nonce_q <= out_nonce;
                        lane_q  <= win_lane;
                    end else if (out_valid) begin
                        nonce_q <= out_nonce;
                    end
                end
                StFound: begin
                    if (rx_ack) begin
                        state_q <= StSearch;
                        found_q <= 1'b0;
                        halt_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign tx_found        = found_q;
    assign tx_halt         = halt_q;
    assign tx_golden_nonce = nonce_q;
    assign tx_golden_lane  = lane_q;

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: scoreboard of expected finds plus directed checks.
module tb_collision_detector;

    localparam logic [159:0] Target = 160'h754d1309a35eb188292dc628947a0e70ab7ccd2a;

    typedef struct {
        logic [59:0] nonce;
        logic [0:0]  lane;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_nonce_valid;
    logic [59:0]   rx_nonce_base;
    logic [319:0]  rx_hash;
    logic [159:0]  rx_target_hash;
    logic          rx_flush;
    logic          rx_ack;
    logic          tx_found;
    logic [59:0]   tx_golden_nonce;
    logic [0:0]    tx_golden_lane;
    logic          tx_halt;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb_q[$];

    collision_detector dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_nonce_valid  (rx_nonce_valid),
        .rx_nonce_base   (rx_nonce_base),
        .rx_hash         (rx_hash),
        .rx_target_hash  (rx_target_hash),
        .rx_flush        (rx_flush),
        .rx_ack          (rx_ack),
        .tx_found        (tx_found),
        .tx_golden_nonce (tx_golden_nonce),
        .tx_golden_lane  (tx_golden_lane),
        .tx_halt         (tx_halt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [319:0] hash_for(input logic [1:0] mask);
        logic [159:0] l0, l1;
        l0 = mask[0] ? Target : ~Target;
        l1 = mask[1] ? Target : ~Target;
        return {l1, l0};
    endfunction

    // Scoreboard consumer: every rising tx_found must match the oldest expectation.
    initial begin
        logic found_prev;
        exp_t e;
        found_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_found === 1'b1 && found_prev !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_found", {63'd0, tx_found}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("sb_nonce", {4'd0, tx_golden_nonce}, {4'd0, e.nonce});
                    check_eq("sb_lane", {63'd0, tx_golden_lane}, {63'd0, e.lane});
                    check_eq("sb_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            found_prev = tx_found;
        end
    end

    // Issue base at edge E0 (pre nonce at E-1); matching hash sampled at E82.
    task automatic run_case(input logic [59:0] base, input logic [1:0] mask, input bit flush,
                            input bit ack_with_match, input bit expect_hit);
        exp_t        e;
        logic [59:0] pre;
        pre            = base ^ 60'h5a5;
        rx_nonce_valid = 1'b1;
        rx_nonce_base  = pre;
        rx_hash        = hash_for(2'b00);
        tick();
        rx_nonce_base = base;
        tick();
        for (int j = 1; j <= 86; j++) begin
            rx_nonce_base = 60'hf00 + 60'(j);
            rx_flush      = flush && (j == 81);
            rx_hash       = (j == 82) ? hash_for(mask) : hash_for(2'b00);
            rx_ack        = ack_with_match && (j == 84);
            if (j == 82 && expect_hit) begin
                e.nonce = base;
                e.lane  = mask[0] ? 1'b0 : 1'b1;
                e.cyc   = cyc + 3;
                sb_q.push_back(e);
            end
            tick();
            if (j == 83) begin
                check_eq("found_early", {63'd0, tx_found}, 64'd0);
                if (!flush) check_eq("progress_nonce", {4'd0, tx_golden_nonce}, {4'd0, pre});
            end
            if (j == 84) begin
                check_eq("found_at_latency", {63'd0, tx_found}, {63'd0, expect_hit});
                check_eq("halt_at_latency", {63'd0, tx_halt}, {63'd0, expect_hit});
            end
        end
        rx_flush = 1'b0;
        rx_ack   = 1'b0;
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        check_eq("ack_found", {63'd0, tx_found}, 64'd0);
        check_eq("ack_halt", {63'd0, tx_halt}, 64'd0);
    endtask

    initial begin
        rst_n          = 1'b1;
        rx_nonce_valid = 1'b0;
        rx_nonce_base  = '0;
        rx_hash        = hash_for(2'b00);
        rx_target_hash = Target;
        rx_flush       = 1'b0;
        rx_ack         = 1'b0;
        #1 rst_n = 1'b0;
        #20;
        check_eq("rst_found", {63'd0, tx_found}, 64'd0);
        check_eq("rst_halt", {63'd0, tx_halt}, 64'd0);
        check_eq("rst_nonce", {4'd0, tx_golden_nonce}, 64'd0);
        check_eq("rst_lane", {63'd0, tx_golden_lane}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lane 0 matches but nothing was ever issued.
        rx_hash = hash_for(2'b01);
        for (int i = 0; i < 100; i++) tick();
        check_eq("garbage_found", {63'd0, tx_found}, 64'd0);
        check_eq("garbage_nonce", {4'd0, tx_golden_nonce}, 64'd0);

        run_case(60'h000000509803064, 2'b10, 1'b0, 1'b0, 1'b1);

        // Later match while FOUND must not disturb the held result.
        rx_hash = hash_for(2'b11);
        tick();
        rx_hash = hash_for(2'b00);
        for (int i = 0; i < 4; i++) tick();
        check_eq("hold_found", {63'd0, tx_found}, 64'd1);
        check_eq("hold_nonce", {4'd0, tx_golden_nonce}, 64'h000000509803064);
        check_eq("hold_lane", {63'd0, tx_golden_lane}, 64'd1);

        // Match in flight at the ack edge is discarded.
        rx_hash = hash_for(2'b11);
        ack_pulse();
        rx_hash = hash_for(2'b00);
        for (int i = 0; i < 6; i++) tick();
        check_eq("inflight_found", {63'd0, tx_found}, 64'd0);

        run_case(60'h000000000000010, 2'b11, 1'b0, 1'b0, 1'b1);
        check_eq("prio_lane", {63'd0, tx_golden_lane}, 64'd0);
        ack_pulse();

        run_case(60'h000000000777123, 2'b01, 1'b1, 1'b0, 1'b0);
        run_case(60'h000000000777123, 2'b01, 1'b0, 1'b1, 1'b1);

        // Reset asserted mid-cycle while FOUND clears outputs without a clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_found", {63'd0, tx_found}, 64'd0);
        check_eq("async_halt", {63'd0, tx_halt}, 64'd0);
        check_eq("async_nonce", {4'd0, tx_golden_nonce}, 64'd0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_eq("post_rst_found", {63'd0, tx_found}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
